// File: rtl/exe_mem_stage_reg.sv
// EXE/MEM pipeline register with architectural NZCV status register and retired-instruction counter.
// Latency: 1 cycle from inputs to outputs; status update visible the cycle after capture.
// Backpressure: freeze holds every register (status and counter included); flush squashes control only.
//
// Ports:
//   clk, rst (sync, active-low)     : clock and reset; reset overrides freeze and flush
//   freeze, flush                   : stall hold / squash of the instruction being captured
//   valid_in, s_in, wb_en_in,
//   mem_r_en_in, mem_w_en_in        : EXE-slot control; controls are gated by valid_in
//   alu_res_in, status_bits_in,
//   st_val_in, dest_in, pc_in       : EXE-slot data; status_bits_in is {N,Z,C,V}
//   status_reg_out                  : architectural NZCV, feeds the ALU carry-in and ID condition check
//   valid_out .. pc_out             : registered MEM-slot fields
//   retired_cnt                     : wrapping count of valid instructions accepted into MEM
module exe_mem_stage_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              s_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [3:0]        status_bits_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic [3:0]        status_reg_out,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] st_val_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic [3:0]        r_status;
    logic              r_valid;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_mem_w_en;
    logic [DATA_W-1:0] r_alu_res;
    logic [DATA_W-1:0] r_st_val;
    logic [DEST_W-1:0] r_dest;
    logic [DATA_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_cnt;

    // A real instruction survives into the MEM slot only if it is valid and not squashed.
    // Freeze is handled by the register enable below, so it is not folded in here.
    logic w_live;
    logic w_status_ld;

    assign w_live      = valid_in & ~flush;
    assign w_status_ld = w_live & s_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_status   <= '0;
            r_valid    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_alu_res  <= '0;
            r_st_val   <= '0;
            r_dest     <= '0;
            r_pc       <= '0;
            r_cnt      <= '0;
        end else if (!freeze) begin
            r_valid    <= w_live;
            r_wb_en    <= wb_en_in    & w_live;
            r_mem_r_en <= mem_r_en_in & w_live;
            r_mem_w_en <= mem_w_en_in & w_live;
            // Data fields follow the inputs even on flush; the cleared controls make them inert.
            r_alu_res  <= alu_res_in;
            r_st_val   <= st_val_in;
            r_dest     <= dest_in;
            r_pc       <= pc_in;
            if (w_status_ld) begin
                r_status <= status_bits_in;
            end
            // Free-running wrap at 2^CNT_W; debug only, no saturation.
            if (w_live) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign status_reg_out = r_status;
    assign valid_out      = r_valid;
    assign wb_en_out      = r_wb_en;
    assign mem_r_en_out   = r_mem_r_en;
    assign mem_w_en_out   = r_mem_w_en;
    assign alu_res_out    = r_alu_res;
    assign st_val_out     = r_st_val;
    assign dest_out       = r_dest;
    assign pc_out         = r_pc;
    assign retired_cnt    = r_cnt;

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Bench for exe_mem_stage_reg: directed steps plus random traffic against a reference model.
// Two instances share stimulus: default widths and a 4-bit retired counter for wrap checks.
// Outputs are sampled 1 time unit after each rising edge.
module tb_exe_mem_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in, s_in, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, st_val_in, pc_in;
    logic [3:0]  status_bits_in, dest_in;

    // instance A (CNT_W = 32)
    logic [3:0]  a_status;
    logic        a_valid, a_wb, a_mr, a_mw;
    logic [31:0] a_alu, a_st, a_pc, a_cnt;
    logic [3:0]  a_dest;
    // instance B (CNT_W = 4)
    logic [3:0]  b_status;
    logic        b_valid, b_wb, b_mr, b_mw;
    logic [31:0] b_alu, b_st, b_pc;
    logic [3:0]  b_dest, b_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [3:0]  m_status;
    logic        m_valid, m_wb, m_mr, m_mw;
    logic [31:0] m_alu, m_st, m_pc;
    logic [3:0]  m_dest;
    int unsigned m_retired;   // total retirements since reset; instances see it modulo their width

    always #5 clk = ~clk;

    exe_mem_stage_reg u_a (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in), .s_in(s_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .status_bits_in(status_bits_in), .st_val_in(st_val_in),
        .dest_in(dest_in), .pc_in(pc_in), .status_reg_out(a_status), .valid_out(a_valid),
        .wb_en_out(a_wb), .mem_r_en_out(a_mr), .mem_w_en_out(a_mw), .alu_res_out(a_alu),
        .st_val_out(a_st), .dest_out(a_dest), .pc_out(a_pc), .retired_cnt(a_cnt)
    );

    exe_mem_stage_reg #(.CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in), .s_in(s_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .status_bits_in(status_bits_in), .st_val_in(st_val_in),
        .dest_in(dest_in), .pc_in(pc_in), .status_reg_out(b_status), .valid_out(b_valid),
        .wb_en_out(b_wb), .mem_r_en_out(b_mr), .mem_w_en_out(b_mw), .alu_res_out(b_alu),
        .st_val_out(b_st), .dest_out(b_dest), .pc_out(b_pc), .retired_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written from the stage rules: what a rising edge does to the MEM slot.
    task automatic model_edge();
        bit live;
        live = valid_in && !flush;
        if (!rst) begin
            m_status = 4'd0; m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
            m_alu = 0; m_st = 0; m_dest = 0; m_pc = 0; m_retired = 0;
        end else if (!freeze) begin
            m_valid = live;
            m_wb    = live && wb_en_in;
            m_mr    = live && mem_r_en_in;
            m_mw    = live && mem_w_en_in;
            m_alu   = alu_res_in;
            m_st    = st_val_in;
            m_dest  = dest_in;
            m_pc    = pc_in;
            if (live && s_in) m_status = status_bits_in;
            if (live) m_retired = m_retired + 1;
        end
    endtask

    task automatic check_all();
        check("a_status", {60'd0, a_status}, {60'd0, m_status});
        check("a_valid",  {63'd0, a_valid},  {63'd0, m_valid});
        check("a_wb",     {63'd0, a_wb},     {63'd0, m_wb});
        check("a_mr",     {63'd0, a_mr},     {63'd0, m_mr});
        check("a_mw",     {63'd0, a_mw},     {63'd0, m_mw});
        check("a_alu",    {32'd0, a_alu},    {32'd0, m_alu});
        check("a_st",     {32'd0, a_st},     {32'd0, m_st});
        check("a_dest",   {60'd0, a_dest},   {60'd0, m_dest});
        check("a_pc",     {32'd0, a_pc},     {32'd0, m_pc});
        check("a_cnt",    {32'd0, a_cnt},    64'(m_retired % 64'h1_0000_0000));
        check("b_status", {60'd0, b_status}, {60'd0, m_status});
        check("b_valid",  {63'd0, b_valid},  {63'd0, m_valid});
        check("b_ctl",    {61'd0, b_wb, b_mr, b_mw}, {61'd0, m_wb, m_mr, m_mw});
        check("b_data",   {b_alu, b_pc},     {m_alu, m_pc});
        check("b_st_dest",{28'd0, b_st, b_dest}, {28'd0, m_st, m_dest});
        check("b_cnt",    {60'd0, b_cnt},    64'(m_retired % 16));
    endtask

    // One clock: inputs are already stable, model follows the edge, outputs checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic rand_data();
        alu_res_in     = $urandom;
        st_val_in      = $urandom;
        pc_in          = $urandom;
        dest_in        = 4'($urandom);
        status_bits_in = 4'($urandom);
        wb_en_in       = 1'($urandom);
        mem_r_en_in    = 1'($urandom);
        mem_w_en_in    = 1'($urandom);
        s_in           = 1'($urandom);
        valid_in       = 1'($urandom);
    endtask

    initial begin
        m_status = 0; m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
        m_alu = 0; m_st = 0; m_dest = 0; m_pc = 0; m_retired = 0;
        @(negedge clk);

        // 1: reset with every input at 1s
        rst = 0; freeze = 1; flush = 1; valid_in = 1; s_in = 1; wb_en_in = 1;
        mem_r_en_in = 1; mem_w_en_in = 1; alu_res_in = '1; st_val_in = '1; pc_in = '1;
        dest_in = '1; status_bits_in = '1;
        tick(); tick();
        check("rst_status_const", {60'd0, a_status}, 64'd0);
        check("rst_cnt_const",    {32'd0, a_cnt},    64'd0);

        // 2: flag-setting valid instruction
        rst = 1; freeze = 0; flush = 0; valid_in = 1; s_in = 1; status_bits_in = 4'b0110;
        alu_res_in = 0; wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
        tick();
        check("t2_status_const", {60'd0, a_status}, 64'b0110);
        check("t2_cnt_const",    {32'd0, a_cnt},    64'd1);

        // 3: no S bit -> status holds, counter still advances
        s_in = 0; status_bits_in = 4'b1000; alu_res_in = 32'h1234;
        tick();
        check("t3_status_const", {60'd0, a_status}, 64'b0110);
        check("t3_cnt_const",    {32'd0, a_cnt},    64'd2);

        // 4: freeze three cycles with changing inputs, flush raised in the middle one
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            rand_data(); valid_in = 1; s_in = 1;
            flush = (i == 1);
            tick();
        end
        check("t4_frozen_cnt_const", {32'd0, a_cnt}, 64'd2);
        freeze = 0; flush = 0; rand_data(); valid_in = 1;
        tick();

        // 5: flush of a flag-setting store
        flush = 1; valid_in = 1; s_in = 1; wb_en_in = 1; mem_w_en_in = 1; status_bits_in = 4'b1111;
        tick();
        check("t5_valid_const", {63'd0, a_valid}, 64'd0);
        check("t5_cnt_const",   {32'd0, a_cnt},   64'd3);
        flush = 0;

        // random traffic, reset rarely
        for (int i = 0; i < 300; i++) begin
            rand_data();
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 4) == 0);
            rst    = ($urandom_range(0, 60) != 0);
            tick();
        end

        // 6: wrap of the 4-bit counter, then reset while frozen
        rst = 0; tick();
        rst = 1; freeze = 0; flush = 0;
        for (int i = 0; i < 16; i++) begin
            rand_data(); valid_in = 1;
            tick();
            if (i == 14) check("t6_cnt15_const", {60'd0, b_cnt}, 64'd15);
        end
        check("t6_wrap_const", {60'd0, b_cnt}, 64'd0);
        check("t6_cnt32_const", {32'd0, a_cnt}, 64'd16);
        freeze = 1; rand_data(); tick();
        rst = 0; tick();
        check("t6_rst_frozen_cnt", {32'd0, a_cnt}, 64'd0);
        check("t6_rst_frozen_pc",  {32'd0, a_pc},  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
